// File: rtl/byte_enabled_sdp_ram_param_if.sv
`default_nettype none
//==============================================================================
// Module   : byte_enabled_sdp_ram_param_if
// Brief    : Write/read port bundle for the byte-enabled simple dual-port RAM
// Revision : 1.0
//==============================================================================
interface byte_enabled_sdp_ram_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  ready;

    modport master (
        output we, be, waddr, wdata, re, raddr,
        input  q, q_valid, ready
    );

    modport slave (
        input  we, be, waddr, wdata, re, raddr,
        output q, q_valid, ready
    );
endinterface
`default_nettype wire

// File: rtl/byte_enabled_sdp_ram_param.sv
`default_nettype none
//==============================================================================
// Module   : byte_enabled_sdp_ram_param
// Brief    : Byte-enabled simple dual-port RAM with power-on clear and valid flag
// Revision : 1.0
//==============================================================================
module byte_enabled_sdp_ram_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int OUT_REG      = 0,
    parameter int BYPASS       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input wire                          clk,
    input wire                          rst,
    byte_enabled_sdp_ram_param_if.slave ram_if
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  ready_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_en;
    logic                  rd_en;
    logic                  clr_en;
    logic                  collide;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_valid_q;

    // User ports are gated by the registered ready, so the cycle in which the
    // FSM enters RUN still ignores them.
    assign wr_en   = ready_q & ram_if.we & ~rst;
    assign rd_en   = ready_q & ram_if.re & ~rst;
    assign clr_en  = (CLEAR_ON_RST != 0) && (state_q == ST_CLEAR) && !rst;
    assign collide = wr_en && (ram_if.waddr == ram_if.raddr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_q == ST_RUN);
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    if ((CLEAR_ON_RST == 0) || (cnt_q == '1)) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (ram_if.be[k]) begin
                    mem[ram_if.waddr][8*k +: 8] <= ram_if.wdata[8*k +: 8];
                end
            end
        end
    end

    // Write-first merge happens per lane; unenabled lanes keep the old word.
    always_comb begin
        rd_data_d = mem[ram_if.raddr];
        if ((BYPASS != 0) && collide) begin
            for (int k = 0; k < NB; k++) begin
                if (ram_if.be[k]) begin
                    rd_data_d[8*k +: 8] = ram_if.wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_en;
            if (rd_en) begin
                s1_data_q <= rd_data_d;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q_q;
            logic                  q_valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    q_q       <= '0;
                    q_valid_q <= 1'b0;
                end else begin
                    q_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        q_q <= s1_data_q;
                    end
                end
            end

            assign ram_if.q       = q_q;
            assign ram_if.q_valid = q_valid_q;
        end else begin : g_no_out_reg
            assign ram_if.q       = s1_data_q;
            assign ram_if.q_valid = s1_valid_q;
        end
    endgenerate

    assign ram_if.ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_enabled_sdp_ram_param.sv
`default_nettype none
// Two configurations (32x256 write-first latency 1, 64x16 read-old latency 2)
// driven in lock-step and compared every cycle against a memory-array model.
module tb_byte_enabled_sdp_ram_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    byte_enabled_sdp_ram_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_a ();
    byte_enabled_sdp_ram_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(4)) bus_b ();

    byte_enabled_sdp_ram_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .OUT_REG(0), .BYPASS(1), .CLEAR_ON_RST(1)
    ) u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .ram_if (bus_a.slave)
    );

    byte_enabled_sdp_ram_param #(
        .DATA_WIDTH(64), .ADDR_WIDTH(4), .OUT_REG(1), .BYPASS(0), .CLEAR_ON_RST(1)
    ) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .ram_if (bus_b.slave)
    );

    logic        drv_we    = 1'b0;
    logic        drv_re    = 1'b0;
    logic [7:0]  drv_be    = '0;
    logic [7:0]  drv_waddr = '0;
    logic [7:0]  drv_raddr = '0;
    logic [63:0] drv_wdata = '0;

    assign bus_a.we    = drv_we;
    assign bus_a.be    = drv_be[3:0];
    assign bus_a.waddr = drv_waddr;
    assign bus_a.wdata = drv_wdata[31:0];
    assign bus_a.re    = drv_re;
    assign bus_a.raddr = drv_raddr;

    assign bus_b.we    = drv_we;
    assign bus_b.be    = drv_be;
    assign bus_b.waddr = drv_waddr[3:0];
    assign bus_b.wdata = drv_wdata;
    assign bus_b.re    = drv_re;
    assign bus_b.raddr = drv_raddr[3:0];

    // Reference model: per-instance word arrays plus results scheduled by the
    // edge number on which they must appear.
    logic [63:0] mem_m [2][256];
    logic        res_v [2][8];
    logic [63:0] res_d [2][8];
    logic [63:0] q_exp [2];
    logic        v_exp [2];
    logic        rdy_exp [2];
    int          run_edges = 0;
    int          edge_n    = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? 256 : 16;
    endfunction

    function automatic int lanes_of(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    task automatic model_edge();
        edge_n++;
        for (int d = 0; d < 2; d++) begin
            int          dep;
            int          wa;
            int          ra;
            int          slot;
            logic        acc;
            logic [63:0] rd;
            dep = depth_of(d);
            wa  = int'(drv_waddr) % dep;
            ra  = int'(drv_raddr) % dep;
            acc = (run_edges >= dep + 1);
            if (rst) begin
                for (int i = 0; i < 256; i++) mem_m[d][i] = '0;
                for (int s = 0; s < 8; s++) res_v[d][s] = 1'b0;
                q_exp[d] = '0;
                v_exp[d] = 1'b0;
            end else begin
                if (acc && drv_re) begin
                    rd = mem_m[d][ra];
                    if (drv_we && (d == 0) && (wa == ra)) begin
                        for (int k = 0; k < lanes_of(d); k++)
                            if (drv_be[k]) rd[8*k +: 8] = drv_wdata[8*k +: 8];
                    end
                    slot = (edge_n + d) % 8;
                    res_v[d][slot] = 1'b1;
                    res_d[d][slot] = rd;
                end
                if (acc && drv_we) begin
                    for (int k = 0; k < lanes_of(d); k++)
                        if (drv_be[k]) mem_m[d][wa][8*k +: 8] = drv_wdata[8*k +: 8];
                end
                slot = edge_n % 8;
                v_exp[d] = res_v[d][slot];
                if (res_v[d][slot]) q_exp[d] = res_d[d][slot];
                res_v[d][slot] = 1'b0;
            end
        end
        run_edges = rst ? 0 : run_edges + 1;
        for (int d = 0; d < 2; d++) rdy_exp[d] = (run_edges >= depth_of(d) + 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        check_eq("a_ready",   64'(bus_a.ready),   64'(rdy_exp[0]));
        check_eq("a_q_valid", 64'(bus_a.q_valid), 64'(v_exp[0]));
        check_eq("a_q",       64'(bus_a.q),       q_exp[0]);
        check_eq("b_ready",   64'(bus_b.ready),   64'(rdy_exp[1]));
        check_eq("b_q_valid", 64'(bus_b.q_valid), 64'(v_exp[1]));
        check_eq("b_q",       bus_b.q,            q_exp[1]);
    endtask

    task automatic set_in(input logic we, input logic [7:0] be, input logic [7:0] wa,
                          input logic [63:0] wd, input logic re, input logic [7:0] ra);
        drv_we    = we;
        drv_be    = be;
        drv_waddr = wa;
        drv_wdata = wd;
        drv_re    = re;
        drv_raddr = ra;
    endtask

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            drv_we    = ($urandom_range(0, 1) == 1);
            drv_re    = ($urandom_range(0, 2) != 0);
            drv_be    = 8'($urandom);
            drv_wdata = {$urandom, $urandom};
            drv_waddr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            drv_raddr = ($urandom_range(0, 3) == 0) ? drv_waddr :
                        (($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom));
            tick();
        end
    endtask

    logic [7:0] clr_addr [3] = '{8'h00, 8'h7F, 8'hFF};

    initial begin
        // Reset, then a clear window with stray traffic that must be ignored
        set_in(1'b0, 8'h00, 8'h00, 64'h0, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rand_cycles(256);
        check_eq("a_ready_at_256", 64'(bus_a.ready), 64'd0);
        set_in(1'b0, 8'h00, 8'h00, 64'h0, 1'b0, 8'h00);
        tick();
        check_eq("a_ready_at_257", 64'(bus_a.ready), 64'd1);

        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 8'h00, 8'h00, 64'h0, 1'b1, clr_addr[i]);
            tick();
            check_eq("clear_rd_valid", 64'(bus_a.q_valid), 64'd1);
            check_eq("clear_rd_q",     64'(bus_a.q),       64'd0);
        end

        // Byte lanes
        set_in(1'b1, 8'h0F, 8'd3, 64'h0000_0000_DEAD_BEEF, 1'b0, 8'd0); tick();
        set_in(1'b1, 8'h05, 8'd3, 64'h0000_0000_1122_3344, 1'b0, 8'd0); tick();
        set_in(1'b1, 8'h00, 8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'd0); tick();
        set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'd3);                    tick();
        check_eq("lanes_a", 64'(bus_a.q), 64'hDE22_BE44);
        set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b0, 8'd0);                    tick();
        check_eq("lanes_b", 64'(bus_b.q[31:0]), 64'hDE22_BE44);

        // Same-address collision: write-first on A, read-old on B
        set_in(1'b1, 8'h0F, 8'd5, 64'h0000_0000_AAAA_AAAA, 1'b0, 8'd0); tick();
        set_in(1'b1, 8'h03, 8'd5, 64'h0000_0000_1234_5678, 1'b1, 8'd5); tick();
        check_eq("collide_a", 64'(bus_a.q), 64'hAAAA_5678);
        set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b0, 8'd0);                    tick();
        check_eq("collide_b", 64'(bus_b.q[31:0]), 64'hAAAA_AAAA);
        set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'd5);                    tick();
        check_eq("after_collide_a", 64'(bus_a.q), 64'hAAAA_5678);
        set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b0, 8'd0);                    tick();
        check_eq("after_collide_b", 64'(bus_b.q[31:0]), 64'hAAAA_5678);

        // Top word of the 64x16 instance: clear it, then set only lane 7
        set_in(1'b1, 8'hFF, 8'd15, 64'h0, 1'b0, 8'd0);                   tick();
        set_in(1'b1, 8'h80, 8'd15, 64'hFF00_0000_0000_0000, 1'b0, 8'd0); tick();
        set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'd15);                   tick();
        set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b0, 8'd0);                    tick();
        check_eq("wide_lane7_b", bus_b.q, 64'hFF00_0000_0000_0000);

        // Back-to-back stream through the 2-cycle pipeline
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, 8'hFF, 8'(i), 64'(i) * 64'h0101_0101_0101_0101, 1'b0, 8'd0);
            tick();
        end
        for (int i = 0; i < 9; i++) begin
            set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'(i));
            tick();
            check_eq("stream_b_valid", 64'(bus_b.q_valid), (i > 0) ? 64'd1 : 64'd0);
            if (i > 0) check_eq("stream_b_q", bus_b.q, 64'(i - 1) * 64'h0101_0101_0101_0101);
        end
        set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b0, 8'd0);
        tick();
        check_eq("stream_b_last", bus_b.q, 64'h0808_0808_0808_0808);

        rand_cycles(1500);

        // Reset while a read is in flight, then re-clear under stray traffic
        set_in(1'b1, 8'hFF, 8'hFF, 64'h0000_0000_CAFE_F00D, 1'b0, 8'd0); tick();
        set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'hFF);                   tick();
        set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b0, 8'd0);
        rst = 1'b1;
        tick();
        check_eq("rst_drop_b_valid", 64'(bus_b.q_valid), 64'd0);
        check_eq("rst_q_zero_a", 64'(bus_a.q), 64'd0);
        rst = 1'b0;
        rand_cycles(257);
        set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'hFF);                   tick();
        check_eq("reclear_a_valid", 64'(bus_a.q_valid), 64'd1);
        check_eq("reclear_a_q",     64'(bus_a.q),       64'd0);

        rand_cycles(500);
        set_in(1'b0, 8'h00, 8'd0, 64'h0, 1'b0, 8'd0);
        tick();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/byte_enabled_sdp_ram_param.md
Name: byte_enabled_sdp_ram_param

Overview:
Parametrised byte-enabled simple dual-port RAM with one write port and one read port.
- Generalised in data width, depth, optional output register stage and read-during-write mode.
- Adds a power-on clear sequencer, a read-enable/valid handshake and a ready flag.
- Serves as data/scratch memory behind the MPU load/store unit; the LSU drives byte enables for SB/SH/SW.

Parameters:
DATA_WIDTH, 32, data bits; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words
OUT_REG, 0, 0: read latency 1 cycle; 1: extra output register, read latency 2 cycles
BYPASS, 1, 1: write-first forwarding on same-address collision; 0: read-old-data
CLEAR_ON_RST, 1, 1: zero every word after reset; 0: memory contents untouched by reset, ready next cycle

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
we  input  1  write strobe
be  input  NB  byte enables; bit k enables wdata[8k+7:8k]
waddr  input  ADDR_WIDTH  write word address
wdata  input  DATA_WIDTH  write data
re  input  1  read strobe
raddr  input  ADDR_WIDTH  read word address
q  output  DATA_WIDTH  read data
q_valid  output  1  one-cycle pulse; q carries data for a read accepted 1+OUT_REG cycles earlier
ready  output  1  high when clear is done and ports are accepted

Behaviour:
- Reset, sampled at a clk edge with rst=1:
  - q=0, q_valid=0, ready=0.
  - Clear counter is set to 0 and all pipeline valid bits are flushed.
- FSM states CLEAR and RUN; CLEAR is the state after reset.
- CLEAR_ON_RST=1:
  - CLEAR writes all-zero to address cnt on each cycle, then cnt increments.
  - After writing DEPTH-1, the FSM moves to RUN and ready goes 1 on the next cycle.
  - ready first goes high exactly DEPTH+1 cycles after rst deasserts.
- CLEAR_ON_RST=0: CLEAR lasts one cycle, then RUN.
- While ready=0:
  - we and re are ignored; no user write happens and no read is accepted.
  - q_valid stays 0 and q holds 0.
- rst asserted mid-clear: the FSM restarts at cnt=0 and the full DEPTH-cycle clear repeats.
- rst asserted in RUN: a new clear starts and in-flight reads are dropped, so q_valid is never asserted for them.
- Write (RUN, we=1):
  - At the clk edge, lane k of mem[waddr] is updated only where be[k]=1.
  - be=0 with we=1 is a no-op.
- Read (RUN, re=1), latency = 1+OUT_REG cycles:
  - OUT_REG=0: q=mem[raddr] and q_valid=1 one edge after the request.
  - OUT_REG=1: the data passes through a second register; q_valid is delayed identically.
  - re=1 on consecutive cycles gives back-to-back reads, one result per cycle in order.
- q holds its last value when no read completes; q_valid=0 on those cycles.
- Same-cycle collision, we=1, re=1, waddr==raddr:
  - BYPASS=1: for lane k, q lane k = wdata lane k if be[k]=1, else the old mem lane.
  - BYPASS=0: q returns the old word entirely.
  - The memory is updated normally in both cases.
- A read of an address written in any earlier cycle always returns the new data.
- Addresses are ADDR_WIDTH bits with no wrap logic needed; address DEPTH-1 is a valid, ordinary word.
- No X on q after reset: q is explicitly initialised, and memory is cleared when CLEAR_ON_RST=1.

Test Plan:
1. Clear (defaults): pulse rst 1 cycle -> ready=0 for 256 cycles, then 1 at cycle 257; reads of addr 0, 0x7F and 0xFF return 0x00000000 with q_valid one cycle after re.
2. Byte lanes: write 0xDEADBEEF be=4'hF to addr 3, then 0x11223344 be=4'b0101 to addr 3 -> read addr 3 returns 0xDE22BE44; we=1 be=0 wdata=0xFFFFFFFF leaves 0xDE22BE44.
3. Collision: mem[5]=0xAAAAAAAA; same cycle we=1 be=4'b0011 wdata=0x12345678 waddr=raddr=5, re=1 -> BYPASS=1 gives q=0xAAAA5678, BYPASS=0 gives q=0xAAAAAAAA; the next read returns 0xAAAA5678 in both modes.
4. Latency/stream (OUT_REG=1): addr i holds i*0x01010101; re=1 for raddr=0..8 on consecutive cycles -> q_valid high for 9 consecutive cycles starting 2 cycles after the first re; q runs 0x00000000..0x08080808 in order.
5. Reset mid-operation: write addr 0xFF=0xCAFEF00D, issue re, assert rst the next cycle -> no q_valid for that read; after the re-clear, addr 0xFF reads 0x00000000; we/re during ready=0 produce no write and no q_valid.
6. Width generalisation: DATA_WIDTH=64, ADDR_WIDTH=4 -> ready after 17 cycles; be=8'h80 wdata=0xFF00000000000000 to addr 15 -> read addr 15 returns 0xFF00000000000000.
